// File: rtl/ddr3_rw_arbiter.sv
// ddr3_rw_arbiter: grants the shared DDR3 command port to one write or read burst at a time,
// then counts that burst's beats and drives its LAST strobe. Define DDR3_ARB_BATCH_EN to batch same-direction bursts.
module ddr3_rw_arbiter #(
    parameter int ADDR_W     = 28,
    parameter int LEN_W      = 4,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] WR_ADDR,
    input  logic [LEN_W-1:0]  WR_LEN,
    input  logic [3:0]        WR_ID,
    input  logic              WR_ADDR_VALID,
    output logic              WR_ADDR_READY,
    output logic              WR_DATA_READY,
    output logic              WR_DATA_LAST,
    input  logic [ADDR_W-1:0] RD_ADDR,
    input  logic [LEN_W-1:0]  RD_LEN,
    input  logic [3:0]        RD_ID,
    input  logic              RD_ADDR_VALID,
    output logic              RD_ADDR_READY,
    output logic              RD_DATA_VALID,
    output logic              RD_DATA_LAST,
    output logic [ADDR_W-1:0] DDR_CMD_ADDR,
    output logic [LEN_W-1:0]  DDR_CMD_LEN,
    output logic [3:0]        DDR_CMD_ID,
    output logic              DDR_CMD_WRITE,
    output logic              DDR_CMD_VALID,
    input  logic              DDR_CMD_READY,
    input  logic              DDR_WDATA_READY,
    input  logic              DDR_RDATA_VALID,
    output logic              ERR_SPURIOUS
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_CMD  = 3'd1;
    localparam logic [2:0] WR_DATA = 3'd2;
    localparam logic [2:0] RD_CMD  = 3'd3;
    localparam logic [2:0] RD_WAIT = 3'd4;

    localparam int STREAK_W = $clog2(MAX_STREAK) + 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

`ifdef DDR3_ARB_BATCH_EN
    localparam logic BATCH = 1'b1;
`else
    localparam logic BATCH = 1'b0;
`endif

    logic [2:0]          state;
    logic [LEN_W-1:0]    cnt;
    logic [STREAK_W-1:0] streak;
    logic                last_wr;
    logic                keep_dir;
    logic                grant_wr;
    logic                in_wr_cmd;
    logic                in_rd_cmd;
    logic                in_wr_data;
    logic                in_rd_wait;
    logic                spurious;

    always_comb begin
        in_wr_cmd  = (state == WR_CMD);
        in_rd_cmd  = (state == RD_CMD);
        in_wr_data = (state == WR_DATA);
        in_rd_wait = (state == RD_WAIT);

        // streak == 0 only out of reset (no history), so the first tie still goes opposite to last_wr
        keep_dir = BATCH && (streak != '0) && (streak < STREAK_MAX);
        if (WR_ADDR_VALID && RD_ADDR_VALID)
            grant_wr = keep_dir ? last_wr : ~last_wr;
        else
            grant_wr = WR_ADDR_VALID;

        DDR_CMD_VALID = in_wr_cmd | in_rd_cmd;
        DDR_CMD_WRITE = in_wr_cmd;
        DDR_CMD_ADDR  = '0;
        DDR_CMD_LEN   = '0;
        DDR_CMD_ID    = '0;
        if (in_wr_cmd) begin
            DDR_CMD_ADDR = WR_ADDR;
            DDR_CMD_LEN  = WR_LEN;
            DDR_CMD_ID   = WR_ID;
        end else if (in_rd_cmd) begin
            DDR_CMD_ADDR = RD_ADDR;
            DDR_CMD_LEN  = RD_LEN;
            DDR_CMD_ID   = RD_ID;
        end

        WR_ADDR_READY = in_wr_cmd & DDR_CMD_READY;
        RD_ADDR_READY = in_rd_cmd & DDR_CMD_READY;
        WR_DATA_READY = in_wr_data & DDR_WDATA_READY;
        WR_DATA_LAST  = in_wr_data & (cnt == '0);
        RD_DATA_VALID = in_rd_wait & DDR_RDATA_VALID;
        RD_DATA_LAST  = in_rd_wait & (cnt == '0);

        spurious = (DDR_WDATA_READY & ~in_wr_data) | (DDR_RDATA_VALID & ~in_rd_wait);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            streak       <= '0;
            last_wr      <= 1'b0;
            ERR_SPURIOUS <= 1'b0;
        end else begin
            if (spurious)
                ERR_SPURIOUS <= 1'b1;
            case (state)
                IDLE: begin
                    if (WR_ADDR_VALID || RD_ADDR_VALID)
                        state <= grant_wr ? WR_CMD : RD_CMD;
                end
                WR_CMD, RD_CMD: begin
                    if (DDR_CMD_READY) begin
                        cnt     <= in_wr_cmd ? WR_LEN : RD_LEN;
                        last_wr <= in_wr_cmd;
                        // streak counts grants in the current direction, saturating
                        if (in_wr_cmd != last_wr)
                            streak <= STREAK_W'(1);
                        else if (streak < STREAK_MAX)
                            streak <= streak + STREAK_W'(1);
                        state <= in_wr_cmd ? WR_DATA : RD_WAIT;
                    end
                end
                WR_DATA: begin
                    if (DDR_WDATA_READY) begin
                        if (cnt == '0)
                            state <= IDLE;
                        else
                            cnt <= cnt - LEN_W'(1);
                    end
                end
                RD_WAIT: begin
                    if (DDR_RDATA_VALID) begin
                        if (cnt == '0)
                            state <= IDLE;
                        else
                            cnt <= cnt - LEN_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
